mem_arbiter: RTL and testbench

- Parametrised N-port arbiter between CPU memory masters (fetch unit, exec units, trap/debug engines) and the single memory port.
- Replaces stage-based muxing of the memory interface with real arbitration: fixed or round-robin, bus locking for read-modify-write, and a no-response timeout.
- Sits between the CPU requesters and the memory controller.
- Both the requester side and the memory side use the existing mem_* signalling.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter in front of the single memory port.
// Fixed or round-robin selection, bus locking for read-modify-write and an
// optional no-response timeout. Completion is passed back with no added latency.
module mem_arbiter #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned RR_MODE   = 1,
   parameter int unsigned TIMEOUT   = 0
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
   input  logic [NUM_PORTS*2-1:0]      req_datasize,
   input  logic [NUM_PORTS-1:0]        req_read,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [NUM_PORTS*DATA_W-1:0] req_writedata,
   input  logic [NUM_PORTS-1:0]        req_lock,
   output logic [DATA_W-1:0]           req_readdata,
   output logic [NUM_PORTS-1:0]        req_done,
   output logic [NUM_PORTS-1:0]        req_err,
   output logic [NUM_PORTS-1:0]        grant,
   output logic [ADDR_W-1:0]           mem_address,
   output logic [1:0]                  mem_datasize,
   output logic                        mem_read,
   output logic                        mem_write,
   output logic [DATA_W-1:0]           mem_writedata,
   input  logic [DATA_W-1:0]           mem_readdata,
   input  logic                        mem_done
);

   localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);
   localparam logic [IdxW-1:0] LastInit   = IdxW'(NUM_PORTS - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StLocked} state_e;

   state_e               state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [IdxW-1:0]      last_q, last_d;
   logic [CntW-1:0]      cnt_q, cnt_d;

   logic [NUM_PORTS-1:0] req_any;
   logic                 own_read, own_write, own_lock, own_req;
   logic                 win_valid;
   logic [IdxW-1:0]      win_idx;

   assign req_any   = req_read | req_write;
   assign own_read  = |(grant_q & req_read);
   assign own_write = |(grant_q & req_write);
   assign own_lock  = |(grant_q & req_lock);
   assign own_req   = own_read | own_write;
   assign grant     = grant_q;

   // Winner search: from port 0 in fixed mode, from last winner + 1 in round-robin mode.
   always_comb begin
      int unsigned start;
      int unsigned cand;
      win_valid = 1'b0;
      win_idx   = '0;
      start     = (RR_MODE != 0) ? ((32'(last_q) + 32'd1) % NUM_PORTS) : 32'd0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         cand = (start + k) % NUM_PORTS;
         if (!win_valid && req_any[cand]) begin
            win_valid = 1'b1;
            win_idx   = IdxW'(cand);
         end
      end
   end

   // Route the owner's address, size and write data; zero when nobody holds the grant.
   always_comb begin
      mem_address   = '0;
      mem_datasize  = '0;
      mem_writedata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_q[i]) begin
            mem_address   = req_address[i*ADDR_W +: ADDR_W];
            mem_datasize  = req_datasize[i*2 +: 2];
            mem_writedata = req_writedata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state logic plus memory strobes and completion pulses.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      req_done     = '0;
      req_err      = '0;
      req_readdata = mem_readdata;
      case (state_q)
         StIdle: begin
            if (win_valid) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               last_d           = win_idx;
               cnt_d            = '0;
               state_d          = StBusy;
            end
         end
         StBusy: begin
            if (own_read && own_write) begin
               // Read and write together is rejected without touching memory.
               req_done = grant_q;
               req_err  = grant_q;
               grant_d  = '0;
               state_d  = StIdle;
            end else begin
               mem_read  = own_read;
               mem_write = own_write;
               if (mem_done) begin
                  // A late mem_done on the timeout cycle still counts as success.
                  req_done = grant_q;
                  if (own_lock) begin
                     state_d = StLocked;
                  end else begin
                     grant_d = '0;
                     state_d = StIdle;
                  end
               end else if ((TIMEOUT != 0) && (cnt_q == TimeoutVal)) begin
                  mem_read     = 1'b0;
                  mem_write    = 1'b0;
                  req_done     = grant_q;
                  req_err      = grant_q;
                  req_readdata = '0;
                  grant_d      = '0;
                  state_d      = StIdle;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StLocked: begin
            // Owner keeps the bus; re-entry to BUSY does not touch last winner.
            if (own_req) begin
               cnt_d   = '0;
               state_d = StBusy;
            end else if (!own_lock) begin
               grant_d = '0;
               state_d = StIdle;
            end
         end
         default: begin
            grant_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         last_q  <= LastInit;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (round-robin with timeout, fixed priority without timeout),
// table-driven arbitration rounds, hand-written corner sequences and random traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int unsigned NP = 3;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic [AW-1:0] addr [NP];
   logic [1:0]    sz   [NP];
   logic [DW-1:0] wdat [NP];
   logic [NP*AW-1:0] req_address;
   logic [NP*2-1:0]  req_datasize;
   logic [NP*DW-1:0] req_writedata;
   logic [DW-1:0]    mem_readdata;

   // Shared per-port payload packed onto the flat buses.
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         req_address[i*AW +: AW]   = addr[i];
         req_datasize[i*2 +: 2]    = sz[i];
         req_writedata[i*DW +: DW] = wdat[i];
      end
   end

   logic [NP-1:0] a_read, a_write, a_lock, a_done, a_err, a_grant;
   logic          a_mem_done, a_mread, a_mwrite;
   logic [DW-1:0] a_readdata, a_mwdata;
   logic [AW-1:0] a_maddr;
   logic [1:0]    a_msize;

   logic [NP-1:0] b_read, b_write, b_lock, b_done, b_err, b_grant;
   logic          b_mem_done, b_mread, b_mwrite;
   logic [DW-1:0] b_readdata, b_mwdata;
   logic [AW-1:0] b_maddr;
   logic [1:0]    b_msize;

   mem_arbiter #(
      .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO)
   ) u_rr (
      .clk(clk), .reset_n(reset_n),
      .req_address(req_address), .req_datasize(req_datasize),
      .req_read(a_read), .req_write(a_write), .req_writedata(req_writedata),
      .req_lock(a_lock), .req_readdata(a_readdata), .req_done(a_done), .req_err(a_err),
      .grant(a_grant), .mem_address(a_maddr), .mem_datasize(a_msize),
      .mem_read(a_mread), .mem_write(a_mwrite), .mem_writedata(a_mwdata),
      .mem_readdata(mem_readdata), .mem_done(a_mem_done)
   );

   mem_arbiter #(
      .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(0)
   ) u_fx (
      .clk(clk), .reset_n(reset_n),
      .req_address(req_address), .req_datasize(req_datasize),
      .req_read(b_read), .req_write(b_write), .req_writedata(req_writedata),
      .req_lock(b_lock), .req_readdata(b_readdata), .req_done(b_done), .req_err(b_err),
      .grant(b_grant), .mem_address(b_maddr), .mem_datasize(b_msize),
      .mem_read(b_mread), .mem_write(b_mwrite), .mem_writedata(b_mwdata),
      .mem_readdata(mem_readdata), .mem_done(b_mem_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      a_read = '0; a_write = '0; a_lock = '0; a_mem_done = 1'b0;
      b_read = '0; b_write = '0; b_lock = '0; b_mem_done = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   function automatic int idx_of(input logic [NP-1:0] v);
      for (int i = 0; i < NP; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Round-robin rule: first requester after the last winner, wrapping.
   function automatic int rr_pick(input logic [NP-1:0] m, input int last);
      for (int k = 1; k <= NP; k++) begin
         if (m[(last + k) % NP]) return (last + k) % NP;
      end
      return -1;
   endfunction

   typedef struct {
      logic [NP-1:0] mask;
      logic          wr;
      logic [NP-1:0] exp_grant;
   } vec_t;

   vec_t rr_tab [10];
   vec_t fx_tab [7];

   // Random-traffic model state.
   int            m_last, m_owner, m_c, m_l, m_win;
   logic [NP-1:0] m_grant;
   bit            m_fresh, m_to, m_fin;
   bit            drop_next [NP];
   bit            is_wr [NP];

   initial begin
      rr_tab[0] = '{3'b111, 1'b0, 3'b001};
      rr_tab[1] = '{3'b111, 1'b1, 3'b010};
      rr_tab[2] = '{3'b111, 1'b0, 3'b100};
      rr_tab[3] = '{3'b111, 1'b1, 3'b001};
      rr_tab[4] = '{3'b101, 1'b0, 3'b100};
      rr_tab[5] = '{3'b011, 1'b1, 3'b001};
      rr_tab[6] = '{3'b100, 1'b0, 3'b100};
      rr_tab[7] = '{3'b010, 1'b1, 3'b010};
      rr_tab[8] = '{3'b011, 1'b0, 3'b001};
      rr_tab[9] = '{3'b110, 1'b1, 3'b010};
      fx_tab[0] = '{3'b111, 1'b0, 3'b001};
      fx_tab[1] = '{3'b111, 1'b1, 3'b001};
      fx_tab[2] = '{3'b111, 1'b0, 3'b001};
      fx_tab[3] = '{3'b110, 1'b1, 3'b010};
      fx_tab[4] = '{3'b100, 1'b0, 3'b100};
      fx_tab[5] = '{3'b101, 1'b1, 3'b001};
      fx_tab[6] = '{3'b010, 1'b0, 3'b010};
      for (int p = 0; p < NP; p++) begin
         addr[p] = '0; sz[p] = '0; wdat[p] = '0;
      end
      mem_readdata = '0;

      do_reset();
      chk("reset_grant", 64'(a_grant), 64'(0));
      chk("reset_mem_rw", 64'({a_mread, a_mwrite}), 64'(0));
      chk("reset_addr", 64'(a_maddr), 64'(0));
      chk("reset_done", 64'({a_done, a_err}), 64'(0));

      // Round-robin table: each entry is an independent arbitration round.
      for (int t = 0; t < 10; t++) begin
         for (int p = 0; p < NP; p++) begin
            addr[p] = {$urandom, $urandom};
            sz[p]   = 2'(p);
            wdat[p] = {$urandom, $urandom};
         end
         if (rr_tab[t].wr) a_write = rr_tab[t].mask;
         else              a_read  = rr_tab[t].mask;
         step();
         #2;
         chk("rr_grant", 64'(a_grant), 64'(rr_tab[t].exp_grant));
         chk("rr_mem_rw", 64'({a_mread, a_mwrite}), 64'(rr_tab[t].wr ? 2'b01 : 2'b10));
         chk("rr_addr", 64'(a_maddr), addr[idx_of(rr_tab[t].exp_grant)]);
         chk("rr_size", 64'(a_msize), 64'(sz[idx_of(rr_tab[t].exp_grant)]));
         if (rr_tab[t].wr) chk("rr_wdata", a_mwdata, wdat[idx_of(rr_tab[t].exp_grant)]);
         a_mem_done   = 1'b1;
         mem_readdata = {$urandom, $urandom};
         #1;
         chk("rr_done", 64'(a_done), 64'(rr_tab[t].exp_grant));
         chk("rr_rdata", a_readdata, mem_readdata);
         step();
         a_mem_done = 1'b0; a_read = '0; a_write = '0;
         #2;
         chk("rr_idle", 64'(a_grant), 64'(0));
      end

      // Fixed-priority table on the second instance.
      for (int t = 0; t < 7; t++) begin
         if (fx_tab[t].wr) b_write = fx_tab[t].mask;
         else              b_read  = fx_tab[t].mask;
         step();
         #2;
         chk("fx_grant", 64'(b_grant), 64'(fx_tab[t].exp_grant));
         chk("fx_addr", 64'(b_maddr), addr[idx_of(fx_tab[t].exp_grant)]);
         b_mem_done = 1'b1;
         #1;
         chk("fx_done", 64'(b_done), 64'(fx_tab[t].exp_grant));
         step();
         b_mem_done = 1'b0; b_read = '0; b_write = '0;
         #2;
         chk("fx_idle", 64'(b_grant), 64'(0));
      end

      // No timeout when TIMEOUT is 0: the access just waits.
      b_read = 3'b010;
      step();
      for (int c = 0; c < 8; c++) begin
         #2;
         chk("fx_wait_done", 64'({b_done, b_err}), 64'(0));
         chk("fx_wait_read", 64'(b_mread), 64'(1));
         step();
      end
      b_mem_done = 1'b1;
      #2;
      chk("fx_late_done", 64'({b_done, b_err}), 64'({3'b010, 3'b000}));
      step();
      b_mem_done = 1'b0; b_read = '0;

      // Single read from port 1, memory answers on the third BUSY cycle.
      addr[1] = 64'h8000_ffff_ffff_fffc; sz[1] = 2'd2;
      a_read = 3'b010;
      step();
      #2;
      chk("single_grant", 64'(a_grant), 64'(3'b010));
      chk("single_read", 64'(a_mread), 64'(1));
      chk("single_addr", 64'(a_maddr), 64'h8000_ffff_ffff_fffc);
      chk("single_size", 64'(a_msize), 64'(2));
      step();
      #2;
      chk("single_wait", 64'(a_done), 64'(0));
      step();
      a_mem_done = 1'b1; mem_readdata = 64'hDEAD_BEEF;
      #2;
      chk("single_done", 64'({a_done, a_err}), 64'({3'b010, 3'b000}));
      chk("single_rdata", a_readdata, 64'hDEAD_BEEF);
      step();
      a_mem_done = 1'b0; a_read = '0;
      #2;
      chk("single_release", 64'(a_grant), 64'(0));
      chk("single_read_off", 64'(a_mread), 64'(0));

      // Locked read-modify-write by port 0 while port 1 waits.
      do_reset();
      addr[0] = 64'h100; wdat[0] = 64'h0123_4567_89ab_cdef;
      a_lock = 3'b001; a_read = 3'b011;
      step();
      #2;
      chk("lock_grant", 64'(a_grant), 64'(3'b001));
      a_mem_done = 1'b1;
      #1;
      chk("lock_rd_done", 64'(a_done), 64'(3'b001));
      step();
      a_mem_done = 1'b0; a_read[0] = 1'b0;
      #2;
      chk("lock_hold", 64'(a_grant), 64'(3'b001));
      chk("lock_quiet", 64'({a_mread, a_mwrite, a_done}), 64'(0));
      step();
      a_write[0] = 1'b1;
      #2;
      chk("lock_hold2", 64'(a_grant), 64'(3'b001));
      step();
      #2;
      chk("lock_wr_grant", 64'(a_grant), 64'(3'b001));
      chk("lock_wr_rw", 64'({a_mread, a_mwrite}), 64'(2'b01));
      chk("lock_wr_addr", 64'(a_maddr), 64'h100);
      chk("lock_wr_data", a_mwdata, 64'h0123_4567_89ab_cdef);
      a_mem_done = 1'b1;
      #1;
      chk("lock_wr_done", 64'(a_done), 64'(3'b001));
      step();
      a_mem_done = 1'b0; a_write[0] = 1'b0; a_lock[0] = 1'b0;
      #2;
      chk("lock_still_held", 64'(a_grant), 64'(3'b001));
      step();
      #2;
      chk("lock_release", 64'(a_grant), 64'(0));
      step();
      #2;
      chk("lock_port1", 64'(a_grant), 64'(3'b010));
      a_mem_done = 1'b1;
      step();
      a_mem_done = 1'b0; a_read = '0;

      // Timeout with no memory answer, then mem_done exactly on the timeout cycle.
      mem_readdata = 64'h1234_5678_9abc_def0;
      a_read = 3'b001;
      step();
      a_read[2] = 1'b1;
      for (int c = 0; c < TO; c++) begin
         #2;
         chk("to_wait_done", 64'(a_done), 64'(0));
         chk("to_wait_read", 64'(a_mread), 64'(1));
         step();
      end
      #2;
      chk("to_done", 64'(a_done), 64'(3'b001));
      chk("to_err", 64'(a_err), 64'(3'b001));
      chk("to_read_drop", 64'(a_mread), 64'(0));
      chk("to_rdata_zero", a_readdata, 64'(0));
      step();
      a_read[0] = 1'b0;
      #2;
      chk("to_idle", 64'(a_grant), 64'(0));
      step();
      #2;
      chk("to_next_grant", 64'(a_grant), 64'(3'b100));
      step();
      for (int c = 1; c < TO; c++) begin
         #2;
         chk("to2_wait", 64'(a_done), 64'(0));
         step();
      end
      a_mem_done = 1'b1;
      #2;
      chk("to2_done", 64'({a_done, a_err}), 64'({3'b100, 3'b000}));
      chk("to2_read", 64'(a_mread), 64'(1));
      chk("to2_rdata", a_readdata, 64'h1234_5678_9abc_def0);
      step();
      a_mem_done = 1'b0; a_read = '0;
      #2;
      chk("to2_idle", 64'(a_grant), 64'(0));

      // Read and write together is rejected on the first BUSY cycle.
      a_read = 3'b010; a_write = 3'b010;
      step();
      #2;
      chk("ill_grant", 64'(a_grant), 64'(3'b010));
      chk("ill_no_access", 64'({a_mread, a_mwrite}), 64'(0));
      chk("ill_done_err", 64'({a_done, a_err}), 64'({3'b010, 3'b010}));
      step();
      a_read = '0; a_write = '0;
      #2;
      chk("ill_idle", 64'(a_grant), 64'(0));

      // Reset in the middle of a write; afterwards port 0 beats port 1 again.
      a_write = 3'b001;
      step();
      a_read[1] = 1'b1;
      #2;
      chk("rst_pre_write", 64'(a_mwrite), 64'(1));
      step();
      reset_n = 1'b0;
      #1;
      chk("rst_grant", 64'(a_grant), 64'(0));
      chk("rst_mem", 64'({a_mread, a_mwrite}), 64'(0));
      chk("rst_addr", 64'(a_maddr), 64'(0));
      chk("rst_done", 64'({a_done, a_err}), 64'(0));
      step();
      reset_n = 1'b1;
      step();
      #2;
      chk("rst_winner", 64'(a_grant), 64'(3'b001));
      a_mem_done = 1'b1;
      step();
      a_mem_done = 1'b0; a_write = '0; a_read = '0;

      // Random traffic against the transaction-level model.
      do_reset();
      m_last = NP - 1; m_grant = '0; m_c = 0; m_l = 0; m_fresh = 1'b0;
      for (int p = 0; p < NP; p++) begin
         drop_next[p] = 1'b0; is_wr[p] = 1'b0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         chk("rand_grant", 64'(a_grant), 64'(m_grant));
         m_owner = idx_of(m_grant);
         for (int p = 0; p < NP; p++) begin
            if (drop_next[p]) begin
               a_read[p] = 1'b0; a_write[p] = 1'b0; drop_next[p] = 1'b0;
            end else if (!(a_read[p] || a_write[p]) && ($urandom_range(0, 2) == 0)) begin
               addr[p]  = {$urandom, $urandom};
               sz[p]    = 2'($urandom_range(0, 3));
               wdat[p]  = {$urandom, $urandom};
               is_wr[p] = 1'($urandom_range(0, 1));
               if (is_wr[p]) a_write[p] = 1'b1;
               else          a_read[p]  = 1'b1;
            end
         end
         if (m_owner >= 0) begin
            if (m_fresh) begin
               m_c = 0; m_l = int'($urandom_range(0, 6)); m_fresh = 1'b0;
            end else begin
               m_c++;
            end
         end
         a_mem_done   = (m_owner >= 0) && (m_c == m_l);
         mem_readdata = {$urandom, $urandom};
         #2;
         if (m_owner < 0) begin
            chk("rand_idle_mem", 64'({a_mread, a_mwrite}), 64'(0));
            chk("rand_idle_addr", 64'(a_maddr), 64'(0));
            chk("rand_idle_done", 64'({a_done, a_err}), 64'(0));
            m_win = rr_pick(a_read | a_write, m_last);
            m_grant = '0;
            if (m_win >= 0) begin
               m_grant[m_win] = 1'b1; m_last = m_win; m_fresh = 1'b1;
            end
         end else begin
            m_to  = (m_c == TO) && (m_l > TO);
            m_fin = (m_c == m_l) || m_to;
            chk("rand_mem_read", 64'(a_mread), 64'(!m_to && !is_wr[m_owner]));
            chk("rand_mem_write", 64'(a_mwrite), 64'(!m_to && is_wr[m_owner]));
            chk("rand_addr", 64'(a_maddr), addr[m_owner]);
            chk("rand_size", 64'(a_msize), 64'(sz[m_owner]));
            chk("rand_wdata", a_mwdata, wdat[m_owner]);
            chk("rand_done", 64'(a_done), 64'(m_fin ? m_grant : 3'b000));
            chk("rand_err", 64'(a_err), 64'(m_to ? m_grant : 3'b000));
            chk("rand_rdata", a_readdata, m_to ? 64'(0) : mem_readdata);
            if (m_fin) begin
               drop_next[m_owner] = 1'b1;
               m_grant = '0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
